// File: rtl/encoder_4_to_2_seq.sv
// Registered 4-to-2 priority encoder: requests are latched into a pending
// register and presented one code at a time on a valid/acknowledge handshake.
module encoder_4_to_2_seq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic ACK,
  output logic A0,
  output logic A1,
  output logic V,
  output logic ANY,
  output logic state_dbg
);

  // Handshake: the code on A1A0 is valid while V=1 and stays frozen until the
  // consumer samples ACK=1 on a rising edge; that edge retires the code and V
  // drops for one cycle before the next code can be presented.

  typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

  state_t     state;
  logic [3:0] pending;
  logic [3:0] req;
  logic [3:0] set_mask;
  logic [3:0] clr_mask;
  logic [3:0] pending_next;
  logic [1:0] code;
  logic [1:0] next_code;

  function automatic logic [1:0] pick(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    if (HIGH_FIRST) begin
      if (p[3])      idx = 2'd3;
      else if (p[2]) idx = 2'd2;
      else if (p[1]) idx = 2'd1;
      else           idx = 2'd0;
    end else begin
      if (p[0])      idx = 2'd0;
      else if (p[1]) idx = 2'd1;
      else if (p[2]) idx = 2'd2;
      else           idx = 2'd3;
    end
    return idx;
  endfunction

  assign req = {D3, D2, D1, D0};

  // A new request on the bit being acknowledged survives: set beats clear.
  always_comb begin
    set_mask     = EN ? req : 4'b0000;
    clr_mask     = 4'b0000;
    if (state == VALID && ACK) clr_mask = 4'b0001 << code;
    pending_next = (pending & ~clr_mask) | set_mask;
    next_code    = pick(pending);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pending <= 4'b0000;
      code    <= 2'b00;
      V       <= 1'b0;
      ANY     <= 1'b0;
    end else begin
      pending <= pending_next;
      ANY     <= |pending_next;
      case (state)
        IDLE: begin
          if (pending != 4'b0000) begin
            code  <= next_code;
            V     <= 1'b1;
            state <= VALID;
          end
        end
        VALID: begin
          if (ACK) begin
            V     <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          V     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign A1        = code[1];
  assign A0        = code[0];
  assign state_dbg = (state == VALID);

endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// Directed bench for encoder_4_to_2_seq: expected codes go into a queue and a
// monitor pops one each time V rises; level checks run in the stimulus thread.
module tb_encoder_4_to_2_seq;

  logic CLK = 1'b0;
  logic RST, EN, D0, D1, D2, D3, ACK;
  logic A0, A1, V, ANY, state_dbg;

  int vectors = 0;
  int errors  = 0;
  logic [1:0] exp_q[$];
  logic       v_prev = 1'b0;

  encoder_4_to_2_seq #(.HIGH_FIRST(1'b1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(ACK),
    .A0(A0), .A1(A1), .V(V), .ANY(ANY),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_d(input logic [3:0] d);
    {D3, D2, D1, D0} = d;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: one code per rising V
  always @(negedge CLK) begin
    if (V === 1'b1 && v_prev !== 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_code: got %b%b, expected no presentation at %0t", A1, A0, $time);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({A1, A0} !== e) begin
          errors++;
          $display("FAIL code: got %b%b, expected %b at %0t", A1, A0, e, $time);
        end
      end
    end
    v_prev = V;
  end

  initial begin
    RST = 1'b1; EN = 1'b1; ACK = 1'b0;
    drive_d(4'b1111);
    #2;

    // reset with requests asserted
    tick(); tick();
    RST = 1'b0;
    drive_d(4'b0000);
    check("reset_v", {3'b0, V}, 4'd0);
    check("reset_any", {3'b0, ANY}, 4'd0);
    check("reset_code", {2'b0, A1, A0}, 4'd0);
    check("reset_state", {3'b0, state_dbg}, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_quiet_v", {3'b0, V}, 4'd0);
    end

    // single request on D2
    drive_d(4'b0100);
    tick();
    drive_d(4'b0000);
    exp_q.push_back(2'b10);
    check("single_any", {3'b0, ANY}, 4'd1);
    check("single_v_early", {3'b0, V}, 4'd0);
    tick();
    check("single_v", {3'b0, V}, 4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_hold", {1'b0, V, A1, A0}, 4'b0110);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("single_ack_v", {3'b0, V}, 4'd0);
    check("single_ack_any", {3'b0, ANY}, 4'd0);

    // priority drain of 1011 with ACK held
    drive_d(4'b1011);
    ACK = 1'b1;
    tick();
    drive_d(4'b0000);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    tick(); check("drain_v1", {2'b0, V, ANY}, 4'b0011);
    tick(); check("drain_gap1", {2'b0, V, ANY}, 4'b0001);
    tick(); check("drain_v2", {2'b0, V, ANY}, 4'b0011);
    tick(); check("drain_gap2", {2'b0, V, ANY}, 4'b0001);
    tick(); check("drain_v3", {2'b0, V, ANY}, 4'b0011);
    tick(); check("drain_done", {2'b0, V, ANY}, 4'b0000);
    ACK = 1'b0;

    // frozen code: D3 arrives while 00 is presented
    drive_d(4'b0001);
    tick();
    drive_d(4'b0000);
    exp_q.push_back(2'b00);
    tick();
    drive_d(4'b1000);
    tick();
    drive_d(4'b0000);
    exp_q.push_back(2'b11);
    check("frozen_code", {1'b0, V, A1, A0}, 4'b0100);
    tick();
    check("frozen_still", {1'b0, V, A1, A0}, 4'b0100);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("frozen_gap", {2'b0, V, ANY}, 4'b0001);
    tick();
    check("frozen_next", {1'b0, V, A1, A0}, 4'b0111);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("frozen_done", {2'b0, V, ANY}, 4'b0000);

    // same, but D3 pulse gated by EN=0
    drive_d(4'b0001);
    tick();
    drive_d(4'b0000);
    exp_q.push_back(2'b00);
    tick();
    EN = 1'b0;
    drive_d(4'b1000);
    tick();
    drive_d(4'b0000);
    EN = 1'b1;
    check("gated_any", {3'b0, ANY}, 4'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gated_quiet", {2'b0, V, ANY}, 4'b0000);
    end

    // set/clear collision on bit 1
    drive_d(4'b0010);
    tick();
    drive_d(4'b0000);
    exp_q.push_back(2'b01);
    tick();
    ACK = 1'b1;
    drive_d(4'b0010);
    tick();
    ACK = 1'b0;
    drive_d(4'b0000);
    exp_q.push_back(2'b01);
    check("collide_gap", {2'b0, V, ANY}, 4'b0001);
    tick();
    check("collide_again", {1'b0, V, A1, A0}, 4'b0101);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("collide_done", {2'b0, V, ANY}, 4'b0000);

    // reset mid-handshake with bits 0 and 3 still pending
    drive_d(4'b0100);
    tick();
    drive_d(4'b0000);
    exp_q.push_back(2'b10);
    tick();
    drive_d(4'b1001);
    tick();
    drive_d(4'b0000);
    check("mid_presenting", {1'b0, V, A1, A0}, 4'b0110);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_reset", {V, ANY, A1, A0}, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_quiet", {2'b0, V, ANY}, 4'b0000);
    end

    // every expected code must have been presented
    check("queue_drained", exp_q.size() > 3 ? 4'hF : 4'(exp_q.size()), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
